move_collision_checker: RTL and testbench

Shared move-legality checker for all maze agents (Pac-Man plus ghosts). Each agent posts its current pixel position and a desired direction. The block arbitrates round-robin and computes the target position one STEP away, with optional left/right tunnel wrap. It queries the wall map through a single registered lookup port with configurable latency and returns legal/blocked plus the resolved target. It sits between the agent movement controllers and the shared wall-map ROM.

---
 rtl/move_collision_checker_pkg.sv | 28 ++
 rtl/move_collision_checker_if.sv | 29 ++
 rtl/move_collision_checker_rr_arbiter.sv | 28 ++
 rtl/move_collision_checker.sv | 201 ++++++++++++++++++++
 tb/tb_move_collision_checker.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/move_collision_checker_pkg.sv
// Shared maze definitions: direction codes, tile size, playfield bounds and FSM states.
package move_collision_checker_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP
    } state_e;

    localparam int unsigned TILE      = 32;
    localparam int unsigned PF_X_MAX  = 640;
    localparam int unsigned PF_Y_MAX  = 480;
    localparam int unsigned COORD_X_W = 10;
    localparam int unsigned COORD_Y_W = 9;

    // Agent id width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/move_collision_checker_if.sv
// Agent-side request/response bundle between movement controllers and the move checker.
interface move_collision_checker_if #(
    parameter int unsigned N_AGENTS = 4,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9
) ();
    localparam int unsigned ID_W = (N_AGENTS > 1) ? $clog2(N_AGENTS) : 1;

    logic [N_AGENTS-1:0]     req_valid;
    logic [2*N_AGENTS-1:0]   req_dir;
    logic [X_W*N_AGENTS-1:0] req_x;
    logic [Y_W*N_AGENTS-1:0] req_y;
    logic [N_AGENTS-1:0]     req_ack;
    logic                    resp_valid;
    logic [ID_W-1:0]         resp_id;
    logic                    resp_ok;
    logic [X_W-1:0]          resp_x;
    logic [Y_W-1:0]          resp_y;

    modport master (
        output req_valid, req_dir, req_x, req_y,
        input  req_ack, resp_valid, resp_id, resp_ok, resp_x, resp_y
    );

    modport slave (
        input  req_valid, req_dir, req_x, req_y,
        output req_ack, resp_valid, resp_id, resp_ok, resp_x, resp_y
    );
endinterface

// File: rtl/move_collision_checker_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            any
);
    int unsigned idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/move_collision_checker.sv
// Shared move-legality checker: arbitrates agents, computes the one-tile target with
// optional horizontal tunnel wrap, and queries the wall map through a latency-counted port.
module move_collision_checker
    import move_collision_checker_pkg::*;
#(
    parameter int unsigned N_AGENTS = 4,
    parameter int unsigned X_W      = COORD_X_W,
    parameter int unsigned Y_W      = COORD_Y_W,
    parameter int unsigned STEP     = TILE,
    parameter int unsigned X_MAX    = PF_X_MAX,
    parameter int unsigned Y_MAX    = PF_Y_MAX,
    parameter int unsigned MAP_LAT  = 1,
    parameter int unsigned WRAP_EN  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    move_collision_checker_if.slave bus,
    output logic [X_W-1:0]          map_x,
    output logic [Y_W-1:0]          map_y,
    input  logic                    map_wall
);
    localparam int unsigned ID_W  = id_width(N_AGENTS);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned XE    = X_W + 1;
    localparam int unsigned YE    = Y_W + 1;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d;
    logic [N_AGENTS-1:0] mask_q, mask_d, ack_q, ack_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [X_W-1:0]      map_x_q, map_x_d, tgt_x_q, tgt_x_d, resp_x_q, resp_x_d;
    logic [Y_W-1:0]      map_y_q, map_y_d, tgt_y_q, tgt_y_d, resp_y_q, resp_y_d;
    logic                resp_valid_q, resp_valid_d, resp_ok_q, resp_ok_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;

    logic [N_AGENTS-1:0] gnt;
    logic [ID_W-1:0]     gnt_id;
    logic                gnt_any;

    rr_arbiter #(.N(N_AGENTS), .ID_W(ID_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (gnt),
        .id    (gnt_id),
        .any   (gnt_any)
    );

    // Target of the granted agent; wide intermediates keep edge tests free of modular wrap.
    int unsigned    sel;
    dir_e           sel_dir;
    logic [X_W-1:0] cur_x, tgt_x;
    logic [Y_W-1:0] cur_y, tgt_y;
    logic [XE-1:0]  xe;
    logic [YE-1:0]  ye;
    logic           in_range;

    always_comb begin
        sel      = 32'(gnt_id);
        sel_dir  = dir_e'(bus.req_dir[2*sel +: 2]);
        cur_x    = bus.req_x[X_W*sel +: X_W];
        cur_y    = bus.req_y[Y_W*sel +: Y_W];
        xe       = {1'b0, cur_x};
        ye       = {1'b0, cur_y};
        tgt_x    = cur_x;
        tgt_y    = cur_y;
        in_range = 1'b1;
        case (sel_dir)
            DIR_UP: begin
                if (ye < YE'(STEP)) in_range = 1'b0;
                else                tgt_y = Y_W'(ye - YE'(STEP));
            end
            DIR_DOWN: begin
                if (ye + YE'(STEP) > YE'(Y_MAX - STEP)) in_range = 1'b0;
                else                                    tgt_y = Y_W'(ye + YE'(STEP));
            end
            DIR_LEFT: begin
                if (xe < XE'(STEP)) begin
                    if (WRAP_EN != 0) tgt_x = X_W'(X_MAX - STEP);
                    else              in_range = 1'b0;
                end else begin
                    tgt_x = X_W'(xe - XE'(STEP));
                end
            end
            DIR_RIGHT: begin
                if (xe + XE'(STEP) > XE'(X_MAX - STEP)) begin
                    if (WRAP_EN != 0) tgt_x = '0;
                    else              in_range = 1'b0;
                end else begin
                    tgt_x = X_W'(xe + XE'(STEP));
                end
            end
            default: in_range = 1'b0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        map_x_d      = map_x_q;
        map_y_d      = map_y_q;
        tgt_x_d      = tgt_x_q;
        tgt_y_d      = tgt_y_q;
        resp_valid_d = 1'b0;
        ack_d        = '0;
        resp_id_d    = resp_id_q;
        resp_ok_d    = resp_ok_q;
        resp_x_d     = resp_x_q;
        resp_y_d     = resp_y_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    id_d    = gnt_id;
                    mask_d  = gnt;
                    tgt_x_d = tgt_x;
                    tgt_y_d = tgt_y;
                    if (in_range) begin
                        map_x_d = tgt_x;
                        map_y_d = tgt_y;
                        cnt_d   = '0;
                        state_d = ST_LOOKUP;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        ack_d        = gnt;
                        resp_id_d    = gnt_id;
                        resp_ok_d    = 1'b0;
                        resp_x_d     = tgt_x;
                        resp_y_d     = tgt_y;
                    end
                end
            end
            ST_LOOKUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(MAP_LAT)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    ack_d        = mask_q;
                    resp_id_d    = id_q;
                    resp_ok_d    = ~map_wall;
                    resp_x_d     = tgt_x_q;
                    resp_y_d     = tgt_y_q;
                end
            end
            ST_RESP: begin
                ptr_d   = (id_q == ID_W'(N_AGENTS - 1)) ? '0 : id_q + ID_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            map_x_q      <= '0;
            map_y_q      <= '0;
            tgt_x_q      <= '0;
            tgt_y_q      <= '0;
            resp_valid_q <= 1'b0;
            ack_q        <= '0;
            resp_id_q    <= '0;
            resp_ok_q    <= 1'b0;
            resp_x_q     <= '0;
            resp_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            map_x_q      <= map_x_d;
            map_y_q      <= map_y_d;
            tgt_x_q      <= tgt_x_d;
            tgt_y_q      <= tgt_y_d;
            resp_valid_q <= resp_valid_d;
            ack_q        <= ack_d;
            resp_id_q    <= resp_id_d;
            resp_ok_q    <= resp_ok_d;
            resp_x_q     <= resp_x_d;
            resp_y_q     <= resp_y_d;
        end
    end

    assign map_x          = map_x_q;
    assign map_y          = map_y_q;
    assign bus.req_ack    = ack_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_ok    = resp_ok_q;
    assign bus.resp_x     = resp_x_q;
    assign bus.resp_y     = resp_y_q;

endmodule

// File: tb/tb_move_collision_checker.sv
// Directed bench: dut_a (MAP_LAT=1, wrap on) and dut_b (MAP_LAT=3, wrap off) against a small wall map.
module tb_move_collision_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    move_collision_checker_if #(.N_AGENTS(4), .X_W(10), .Y_W(9)) if_a ();
    move_collision_checker_if #(.N_AGENTS(4), .X_W(10), .Y_W(9)) if_b ();

    logic [9:0] map_x_a, map_x_b;
    logic [8:0] map_y_a, map_y_b;
    logic       map_wall_a, map_wall_b;
    logic       wall_b_p1 = 1'b0, wall_b_p2 = 1'b0;

    function automatic logic wall_at(input logic [9:0] x, input logic [8:0] y);
        return (x == 10'd64 && y == 9'd32) || (x == 10'd256 && y == 9'd128);
    endfunction

    // Map A answers in the same cycle; map B lags the address by two extra registers.
    assign map_wall_a = wall_at(map_x_a, map_y_a);
    always @(posedge clk) begin
        wall_b_p1 <= wall_at(map_x_b, map_y_b);
        wall_b_p2 <= wall_b_p1;
    end
    assign map_wall_b = wall_b_p2;

    move_collision_checker #(.N_AGENTS(4), .MAP_LAT(1), .WRAP_EN(1)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .map_x(map_x_a), .map_y(map_y_a), .map_wall(map_wall_a)
    );
    move_collision_checker #(.N_AGENTS(4), .MAP_LAT(3), .WRAP_EN(0)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .map_x(map_x_b), .map_y(map_y_b), .map_wall(map_wall_b)
    );

    task automatic post(input bit use_b, input int ag, input logic [9:0] x, input logic [8:0] y,
                        input logic [1:0] dir);
        if (use_b) begin
            if_b.req_valid[ag]     = 1'b1;
            if_b.req_dir[2*ag +: 2] = dir;
            if_b.req_x[10*ag +: 10] = x;
            if_b.req_y[9*ag +: 9]   = y;
        end else begin
            if_a.req_valid[ag]     = 1'b1;
            if_a.req_dir[2*ag +: 2] = dir;
            if_a.req_x[10*ag +: 10] = x;
            if_a.req_y[9*ag +: 9]   = y;
        end
    endtask

    // Counts rising edges until resp_valid is seen at a falling edge; returns at that falling edge.
    task automatic wait_resp(input bit use_b, input bit drop, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if ((use_b ? if_b.resp_valid : if_a.resp_valid) === 1'b1) seen = 1'b1;
        end
        if (seen && drop) begin
            if (use_b) if_b.req_valid[if_b.resp_id] = 1'b0;
            else       if_a.req_valid[if_a.resp_id] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({if_a.resp_valid, if_a.req_ack, if_a.resp_ok} !== 6'd0)
            $display("FAIL reset_strobes: got %b want 0", {if_a.resp_valid, if_a.req_ack, if_a.resp_ok});
        else passed++;
        checks++; if (if_a.resp_id !== 2'd0)
            $display("FAIL reset_id: got %0d want 0", if_a.resp_id);
        else passed++;
        checks++; if ({if_a.resp_x, if_a.resp_y} !== 19'd0)
            $display("FAIL reset_resp_xy: got %0d,%0d want 0,0", if_a.resp_x, if_a.resp_y);
        else passed++;
        checks++; if ({map_x_a, map_y_a, map_x_b, map_y_b} !== 38'd0)
            $display("FAIL reset_map: got %0d,%0d want 0,0", map_x_a, map_y_a);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cyc; bit seen;
        post(1'b0, 0, 10'd320, 9'd224, 2'b11);
        wait_resp(1'b0, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 2)
            $display("FAIL single_latency: got %0d seen %0d want 2", cyc, seen);
        else passed++;
        checks++; if ({if_a.resp_ok, if_a.resp_id} !== 3'b1_00)
            $display("FAIL single_ok_id: got ok %0d id %0d want ok 1 id 0", if_a.resp_ok, if_a.resp_id);
        else passed++;
        checks++; if (if_a.resp_x !== 10'd352 || if_a.resp_y !== 9'd224)
            $display("FAIL single_xy: got %0d,%0d want 352,224", if_a.resp_x, if_a.resp_y);
        else passed++;
        checks++; if (if_a.req_ack !== 4'b0001)
            $display("FAIL single_ack: got %b want 0001", if_a.req_ack);
        else passed++;
        checks++; if (map_x_a !== 10'd352 || map_y_a !== 9'd224)
            $display("FAIL single_map: got %0d,%0d want 352,224", map_x_a, map_y_a);
        else passed++;
        @(negedge clk);
        checks++; if ({if_a.resp_valid, if_a.req_ack} !== 5'd0)
            $display("FAIL single_pulse: got %b want 00000", {if_a.resp_valid, if_a.req_ack});
        else passed++;
        checks++; if (if_a.resp_x !== 10'd352 || if_a.resp_ok !== 1'b1)
            $display("FAIL single_hold: got %0d ok %0d want 352 ok 1", if_a.resp_x, if_a.resp_ok);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_wall();
        int cyc; bit seen;
        post(1'b0, 2, 10'd64, 9'd64, 2'b00);
        wait_resp(1'b0, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 2)
            $display("FAIL wall_latency: got %0d seen %0d want 2", cyc, seen);
        else passed++;
        checks++; if (if_a.resp_ok !== 1'b0 || if_a.resp_id !== 2'd2)
            $display("FAIL wall_ok_id: got ok %0d id %0d want ok 0 id 2", if_a.resp_ok, if_a.resp_id);
        else passed++;
        checks++; if (if_a.resp_x !== 10'd64 || if_a.resp_y !== 9'd32 || if_a.req_ack !== 4'b0100)
            $display("FAIL wall_xy_ack: got %0d,%0d ack %b want 64,32 ack 0100",
                     if_a.resp_x, if_a.resp_y, if_a.req_ack);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        int cyc; bit seen;
        post(1'b0, 1, 10'd0, 9'd96, 2'b10);
        wait_resp(1'b0, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 2 || if_a.resp_ok !== 1'b1)
            $display("FAIL wrap_left_resp: got cyc %0d ok %0d want cyc 2 ok 1", cyc, if_a.resp_ok);
        else passed++;
        checks++; if (map_x_a !== 10'd608 || if_a.resp_x !== 10'd608 || if_a.resp_y !== 9'd96)
            $display("FAIL wrap_left_xy: got map %0d resp %0d,%0d want 608 608,96",
                     map_x_a, if_a.resp_x, if_a.resp_y);
        else passed++;
        repeat (2) @(negedge clk);
        post(1'b0, 3, 10'd608, 9'd96, 2'b11);
        wait_resp(1'b0, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 2 || if_a.resp_ok !== 1'b1 || if_a.resp_id !== 2'd3)
            $display("FAIL wrap_right_resp: got cyc %0d ok %0d id %0d want 2 1 3",
                     cyc, if_a.resp_ok, if_a.resp_id);
        else passed++;
        checks++; if (map_x_a !== 10'd0 || if_a.resp_x !== 10'd0)
            $display("FAIL wrap_right_xy: got map %0d resp %0d want 0 0", map_x_a, if_a.resp_x);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        int cyc; bit seen;
        post(1'b1, 1, 10'd256, 9'd160, 2'b00);
        wait_resp(1'b1, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 4)
            $display("FAIL lat3_wall_latency: got %0d seen %0d want 4", cyc, seen);
        else passed++;
        checks++; if (if_b.resp_ok !== 1'b0 || if_b.resp_id !== 2'd1 || if_b.resp_y !== 9'd128)
            $display("FAIL lat3_wall_resp: got ok %0d id %0d y %0d want 0 1 128",
                     if_b.resp_ok, if_b.resp_id, if_b.resp_y);
        else passed++;
        repeat (2) @(negedge clk);
        post(1'b1, 2, 10'd96, 9'd64, 2'b01);
        wait_resp(1'b1, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 4)
            $display("FAIL lat3_free_latency: got %0d seen %0d want 4", cyc, seen);
        else passed++;
        checks++; if (if_b.resp_ok !== 1'b1 || if_b.resp_x !== 10'd96 || if_b.resp_y !== 9'd96)
            $display("FAIL lat3_free_resp: got ok %0d %0d,%0d want 1 96,96",
                     if_b.resp_ok, if_b.resp_x, if_b.resp_y);
        else passed++;
        repeat (2) @(negedge clk);
        post(1'b1, 3, 10'd96, 9'd448, 2'b01);
        wait_resp(1'b1, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 1 || if_b.resp_ok !== 1'b0 || if_b.resp_id !== 2'd3)
            $display("FAIL bottom_edge: got cyc %0d ok %0d id %0d want 1 0 3",
                     cyc, if_b.resp_ok, if_b.resp_id);
        else passed++;
        checks++; if (map_x_b !== 10'd96 || map_y_b !== 9'd96)
            $display("FAIL bottom_map_hold: got %0d,%0d want 96,96", map_x_b, map_y_b);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap_off();
        int cyc; bit seen;
        post(1'b1, 0, 10'd0, 9'd96, 2'b10);
        wait_resp(1'b1, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 1)
            $display("FAIL nowrap_latency: got %0d seen %0d want 1", cyc, seen);
        else passed++;
        checks++; if (if_b.resp_ok !== 1'b0 || if_b.resp_id !== 2'd0 || if_b.req_ack !== 4'b0001)
            $display("FAIL nowrap_resp: got ok %0d id %0d ack %b want 0 0 0001",
                     if_b.resp_ok, if_b.resp_id, if_b.req_ack);
        else passed++;
        checks++; if (map_x_b !== 10'd96 || map_y_b !== 9'd96)
            $display("FAIL nowrap_map_hold: got %0d,%0d want 96,96", map_x_b, map_y_b);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int cyc; bit seen;
        logic [1:0] want_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) post(1'b0, i, 10'(32 * (i + 2)), 9'd224, 2'b11);
        for (int n = 0; n < 5; n++) begin
            wait_resp(1'b0, 1'b0, cyc, seen);
            checks++; if (!seen || if_a.resp_id !== want_id[n])
                $display("FAIL rr_id[%0d]: got %0d seen %0d want %0d", n, if_a.resp_id, seen, want_id[n]);
            else passed++;
            checks++; if (cyc != ((n == 0) ? 2 : 3))
                $display("FAIL rr_gap[%0d]: got %0d want %0d", n, cyc, (n == 0) ? 2 : 3);
            else passed++;
        end
        checks++; if (if_a.resp_x !== 10'd96 || if_a.resp_ok !== 1'b1)
            $display("FAIL rr_last_xy: got %0d ok %0d want 96 ok 1", if_a.resp_x, if_a.resp_ok);
        else passed++;
        if_a.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen;
        post(1'b0, 1, 10'd320, 9'd224, 2'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_a.req_valid = '0;
        @(negedge clk);
        checks++; if (if_a.resp_valid !== 1'b0 || map_x_a !== 10'd288)
            $display("FAIL midrst_lookup: got valid %0d map_x %0d want 0 288", if_a.resp_valid, map_x_a);
        else passed++;
        @(negedge clk);
        checks++; if ({if_a.resp_valid, if_a.req_ack, if_a.resp_ok, if_a.resp_id} !== 8'd0)
            $display("FAIL midrst_strobes: got %b want 0",
                     {if_a.resp_valid, if_a.req_ack, if_a.resp_ok, if_a.resp_id});
        else passed++;
        checks++; if ({if_a.resp_x, if_a.resp_y, map_x_a, map_y_a} !== 38'd0)
            $display("FAIL midrst_coords: got %0d,%0d map %0d,%0d want 0",
                     if_a.resp_x, if_a.resp_y, map_x_a, map_y_a);
        else passed++;
        rst = 1'b0;
        post(1'b0, 1, 10'd320, 9'd224, 2'b10);
        post(1'b0, 0, 10'd320, 9'd224, 2'b11);
        wait_resp(1'b0, 1'b1, cyc, seen);
        checks++; if (!seen || cyc != 2 || if_a.resp_id !== 2'd0)
            $display("FAIL midrst_after: got cyc %0d id %0d want 2 0", cyc, if_a.resp_id);
        else passed++;
        checks++; if (if_a.resp_x !== 10'd352 || if_a.resp_ok !== 1'b1)
            $display("FAIL midrst_after_xy: got %0d ok %0d want 352 1", if_a.resp_x, if_a.resp_ok);
        else passed++;
        if_a.req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        if_a.req_valid = '0; if_a.req_dir = '0; if_a.req_x = '0; if_a.req_y = '0;
        if_b.req_valid = '0; if_b.req_dir = '0; if_b.req_x = '0; if_b.req_y = '0;
        test_reset();
        test_single();
        test_wall();
        test_wrap();
        test_latency();
        test_wrap_off();
        test_round_robin();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
